// File: rtl/shiftreg_pkg.sv
// Shared types and constants for the serial-to-parallel shift register.
// State encoding, bit-order names and the default word width.
package shiftreg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam string DIR_LEFT  = "LEFT";
  localparam string DIR_RIGHT = "RIGHT";

  localparam int DEF_WIDTH = 16;

endpackage

// File: rtl/shiftreg_bitcnt.sv
// Bit counter for the deserialiser: sync clear, increment, terminal count.
// i_clr+i_inc together load 1 (bit 0 captured on the clearing edge).
module shiftreg_bitcnt #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_inc ? CW'(1) : '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/shiftreg_16_left_deser.sv
// Framed serial-to-parallel receiver with valid/ack hand-off and overrun flag.
// Ports: Clock, Aclr_n, Start, Enable, ShiftIn, Ack, ClrErr -> Q, Valid, Busy, Overrun.
module shiftreg_16_left_deser
  import shiftreg_pkg::*;
#(
  parameter int    lpm_width     = DEF_WIDTH,
  parameter string lpm_direction = DIR_LEFT
) (
  input  logic                 Clock,
  input  logic                 Aclr_n,
  input  logic                 Start,
  input  logic                 Enable,
  input  logic                 ShiftIn,
  input  logic                 Ack,
  input  logic                 ClrErr,
  output logic [lpm_width-1:0] Q,
  output logic                 Valid,
  output logic                 Busy,
  output logic                 Overrun
);

  localparam int CW = $clog2(lpm_width) + 1;
  localparam bit LSB_FIRST = (lpm_direction == DIR_RIGHT);

  state_t               r_state;
  state_t               w_next;
  logic                 r_rel;
  logic [lpm_width-1:0] r_sh;
  logic [lpm_width-1:0] r_q;
  logic                 r_valid;
  logic                 r_ovr;
  logic [CW-1:0]        w_cnt;
  logic                 w_tc;
  logic                 w_done;
  logic                 w_load;
  logic                 w_cnt_clr;
  logic                 w_cnt_inc;
  logic [lpm_width-1:0] w_word;
  logic [lpm_width-1:0] w_sh_next;

  function automatic logic [lpm_width-1:0] f_shift(
    input logic [lpm_width-1:0] v,
    input logic                 b
  );
    if (LSB_FIRST) return {b, v[lpm_width-1:1]};
    else           return {v[lpm_width-2:0], b};
  endfunction

  // Release is taken one edge late, so the first edge after
  // Aclr_n rises behaves as a plain IDLE cycle.
  always_ff @(posedge Clock or negedge Aclr_n) begin
    if (!Aclr_n) r_rel <= 1'b0;
    else         r_rel <= 1'b1;
  end

  assign w_done = r_rel && (r_state == SHIFT) && Enable && w_tc;
  assign w_load = !r_valid || Ack;
  assign w_word = f_shift(r_sh, ShiftIn);

  // Completion wins over Start; a coincident Start then opens
  // a fresh frame at bit 0 without consuming a bit.
  assign w_cnt_clr = !r_rel || w_done || Start;
  assign w_cnt_inc = r_rel && Enable && !w_done
                     && (Start || (r_state == SHIFT));

  shiftreg_bitcnt #(
    .WIDTH(lpm_width),
    .CW   (CW)
  ) u_bitcnt (
    .i_clk  (Clock),
    .i_rst_n(Aclr_n),
    .i_clr  (w_cnt_clr),
    .i_inc  (w_cnt_inc),
    .o_cnt  (w_cnt),
    .o_tc   (w_tc)
  );

  always_ff @(posedge Clock or negedge Aclr_n) begin
    if (!Aclr_n) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!r_rel) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:  if (Start) w_next = SHIFT;
        SHIFT: if (w_done && !Start) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    Busy = (r_state == SHIFT);
  end

  always_comb begin
    w_sh_next = r_sh;
    if (w_done) begin
      w_sh_next = '0;
    end else if (Start) begin
      w_sh_next = Enable ? f_shift('0, ShiftIn) : '0;
    end else if ((r_state == SHIFT) && Enable) begin
      w_sh_next = w_word;
    end
  end

  always_ff @(posedge Clock or negedge Aclr_n) begin
    if (!Aclr_n) begin
      r_sh    <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (!r_rel) begin
      r_sh    <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_sh <= w_sh_next;
      if (w_done && w_load) r_q <= w_word;
      r_valid <= w_done || (r_valid && !Ack);
      r_ovr   <= (w_done && !w_load) || (r_ovr && !ClrErr);
    end
  end

  assign Q       = r_q;
  assign Valid   = r_valid;
  assign Overrun = r_ovr;

endmodule

// File: tb/tb_shiftreg_16_left_deser.sv
// Directed bench: LEFT and RIGHT instances share the serial stimulus.
// Table of frames plus hand sequences for restart, reset and ack corners.
module tb_shiftreg_16_left_deser;

  logic        clk = 1'b0;
  logic        Aclr_n = 1'b0;
  logic        Start = 1'b0;
  logic        Enable = 1'b0;
  logic        ShiftIn = 1'b0;
  logic        Ack = 1'b0;
  logic        ClrErr = 1'b0;
  logic [15:0] QL, QR;
  logic        VL, VR, BL, BR, OL, OR_;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shiftreg_16_left_deser #(
    .lpm_width(16), .lpm_direction("LEFT")
  ) u_left (
    .Clock(clk), .Aclr_n(Aclr_n), .Start(Start), .Enable(Enable),
    .ShiftIn(ShiftIn), .Ack(Ack), .ClrErr(ClrErr),
    .Q(QL), .Valid(VL), .Busy(BL), .Overrun(OL)
  );

  shiftreg_16_left_deser #(
    .lpm_width(16), .lpm_direction("RIGHT")
  ) u_right (
    .Clock(clk), .Aclr_n(Aclr_n), .Start(Start), .Enable(Enable),
    .ShiftIn(ShiftIn), .Ack(Ack), .ClrErr(ClrErr),
    .Q(QR), .Valid(VR), .Busy(BR), .Overrun(OR_)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // gap 4 means a varying gap of (bit index mod 4) cycles
  task automatic send_bits(input logic [15:0] w, input int n,
                           input bit lsb, input int gap,
                           input bit start0, input bit start_last,
                           input bit ack_last);
    int g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      Start   = (start0 && i == 0) || (start_last && i == n - 1);
      Enable  = 1'b1;
      ShiftIn = lsb ? w[i] : w[15 - i];
      Ack     = ack_last && (i == n - 1);
      g = (gap == 4) ? (i % 4) : gap;
      if (i < n - 1) begin
        repeat (g) begin
          @(negedge clk);
          Start = 1'b0; Enable = 1'b0; Ack = 1'b0;
        end
      end
    end
    @(negedge clk);
    Start = 1'b0; Enable = 1'b0; Ack = 1'b0; ShiftIn = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk); Ack = 1'b1;
    @(negedge clk); Ack = 1'b0;
  endtask

  typedef struct {
    logic [15:0] w;
    bit          lsb;
    int          gap;
    bit          ack;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    bit          exp_v;
    bit          exp_o;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{16'hA5C3, 1'b0, 0, 1'b1, 16'hA5C3, 16'hC3A5, 1'b1, 1'b0};
    tbl[1] = '{16'hA5C3, 1'b1, 4, 1'b1, 16'hC3A5, 16'hA5C3, 1'b1, 1'b0};
    tbl[2] = '{16'hA5C3, 1'b1, 3, 1'b1, 16'hC3A5, 16'hA5C3, 1'b1, 1'b0};
    tbl[3] = '{16'h1234, 1'b0, 1, 1'b0, 16'h1234, 16'h2C48, 1'b1, 1'b0};
    tbl[4] = '{16'hFFFF, 1'b0, 0, 1'b0, 16'h1234, 16'h2C48, 1'b1, 1'b1};

    #12;
    chk("rst_Q", 32'(QL), 32'h0);
    chk("rst_Valid", 32'(VL), 32'h0);
    chk("rst_Busy", 32'(BL), 32'h0);
    chk("rst_Overrun", 32'(OL), 32'h0);
    @(negedge clk); Aclr_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      send_bits(tbl[k].w, 16, tbl[k].lsb, tbl[k].gap, 1'b1, 1'b0, 1'b0);
      chk($sformatf("row%0d_QL", k), 32'(QL), 32'(tbl[k].exp_l));
      chk($sformatf("row%0d_QR", k), 32'(QR), 32'(tbl[k].exp_r));
      chk($sformatf("row%0d_Valid", k), 32'(VL), 32'(tbl[k].exp_v));
      chk($sformatf("row%0d_Busy", k), 32'(BL), 32'h0);
      chk($sformatf("row%0d_OvrL", k), 32'(OL), 32'(tbl[k].exp_o));
      chk($sformatf("row%0d_OvrR", k), 32'(OR_), 32'(tbl[k].exp_o));
      if (tbl[k].ack) begin
        do_ack();
        chk($sformatf("row%0d_ackV", k), 32'(VL), 32'h0);
      end
    end

    @(negedge clk); ClrErr = 1'b1;
    @(negedge clk); ClrErr = 1'b0;
    chk("clrerr_OvrL", 32'(OL), 32'h0);
    chk("clrerr_OvrR", 32'(OR_), 32'h0);
    do_ack();
    chk("ack_V", 32'(VL), 32'h0);
    chk("ack_Qhold", 32'(QL), 32'h1234);

    // ack coincides with completion while a word is pending
    send_bits(16'h1111, 16, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    send_bits(16'h00FF, 16, 1'b0, 0, 1'b1, 1'b0, 1'b1);
    chk("ackcomp_Q", 32'(QL), 32'h00FF);
    chk("ackcomp_V", 32'(VL), 32'h1);
    chk("ackcomp_Ovr", 32'(OL), 32'h0);
    do_ack();

    // restart after 7 bits
    send_bits(16'hFE00, 7, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("partial_Busy", 32'(BL), 32'h1);
    chk("partial_V", 32'(VL), 32'h0);
    send_bits(16'h8001, 16, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("restart_Q", 32'(QL), 32'h8001);
    chk("restart_V", 32'(VL), 32'h1);

    // async reset mid-frame
    send_bits(16'hFFFF, 9, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    #2 Aclr_n = 1'b0;
    #1;
    chk("arst_Q", 32'(QL), 32'h0);
    chk("arst_QR", 32'(QR), 32'h0);
    chk("arst_V", 32'(VL), 32'h0);
    chk("arst_Busy", 32'(BL), 32'h0);
    chk("arst_Ovr", 32'(OL), 32'h0);
    @(negedge clk); Aclr_n = 1'b1;
    send_bits(16'hFFFF, 16, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("nostart_V", 32'(VL), 32'h0);
    chk("nostart_Busy", 32'(BL), 32'h0);
    chk("nostart_Q", 32'(QL), 32'h0);

    // Start on the final bit: word completes, next frame opens
    send_bits(16'h0F0F, 16, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    chk("startlast_Q", 32'(QL), 32'h0F0F);
    chk("startlast_V", 32'(VL), 32'h1);
    chk("startlast_Busy", 32'(BL), 32'h1);
    do_ack();
    send_bits(16'h3C3C, 16, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("follow_Q", 32'(QL), 32'h3C3C);
    chk("follow_V", 32'(VL), 32'h1);
    chk("follow_Busy", 32'(BL), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shiftreg_16_left_deser.md
SHIFTREG_16_LEFT_DESER -- requirements
Module: shiftreg_16_left_deser

Interface
REQ-001 Parameter lpm_width, default 16, word width in bits (legal range 2..32).
REQ-002 Parameter lpm_direction, default "LEFT", bit order: "LEFT" = MSB first, "RIGHT" = LSB first.
REQ-003 Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Aclr_n  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  frame strobe; aligns the bit counter to bit 0.
REQ-006 Enable  input  1  bit strobe; ShiftIn is sampled only when high.
REQ-007 ShiftIn  input  1  serial data, i.e. the ShiftOut stream of the peer shift register.
REQ-008 Ack  input  1  consumer acknowledge of the presented word.
REQ-009 ClrErr  input  1  clears Overrun.
REQ-010 Q  output  lpm_width  last completed word.
REQ-011 Valid  output  1  Q holds an unacknowledged word.
REQ-012 Busy  output  1  frame reception in progress.
REQ-013 Overrun  output  1  sticky flag: a word was dropped.

Function
REQ-014 The FSM SHALL have states IDLE and SHIFT; Busy SHALL be 1 exactly in SHIFT.
REQ-015 IDLE: Enable without Start SHALL be ignored; Start SHALL enter SHIFT with bit count 0.
REQ-016 Start and Enable high in the same cycle SHALL capture that cycle's ShiftIn as bit 0.
REQ-017 SHIFT: each Enable SHALL shift ShiftIn into the internal register and increment the count.
REQ-018 "LEFT" SHALL shift toward the MSB, so the first bit received ends up in Q[lpm_width-1].
REQ-019 "RIGHT" SHALL shift toward the LSB, so the first bit received ends up in Q[0].
REQ-020 On the edge that samples bit lpm_width-1, the word SHALL transfer to Q, Valid SHALL set, and the FSM SHALL return to IDLE.
REQ-021 Q and Valid SHALL be visible in the cycle after the final bit edge (1-cycle latency).
REQ-022 Start during SHIFT SHALL discard the partial word and restart at bit 0; REQ-016 applies.
REQ-023 Start coinciding with the final bit SHALL complete the word first, then remain in SHIFT at bit 0.
REQ-024 Ack while Valid SHALL clear Valid on the next edge; Ack while Valid is 0 SHALL be ignored.
REQ-025 Word completion while Valid=1 and Ack=0 SHALL leave Q unchanged, keep Valid=1, and set Overrun.
REQ-026 Word completion with Valid=1 and Ack=1 in the same cycle SHALL load the new word with Valid=1, and SHALL NOT set Overrun.
REQ-027 Overrun SHALL hold until ClrErr; if ClrErr and a new overrun occur together, the overrun SHALL win.
REQ-028 Q SHALL change only on word completion; it SHALL hold after Ack.
REQ-029 The bit counter SHALL be ceil(log2(lpm_width))+1 bits wide and SHALL never exceed lpm_width-1.

Reset
REQ-030 Aclr_n=0 SHALL immediately force IDLE, bit count 0, shift register 0, Q=0, Valid=0, Busy=0 and Overrun=0.
REQ-031 Reset during SHIFT SHALL discard the partial word; after release, only Start begins a new frame.
REQ-032 Reset release SHALL be synchronised to Clock internally; the first edge after release SHALL be treated as an IDLE cycle.

Structure
REQ-033 Package shiftreg_pkg SHALL hold the state enum (IDLE, SHIFT), the direction constants "LEFT"/"RIGHT" and the default width 16.
REQ-034 The bit counter SHALL be the sub-module shiftreg_bitcnt (clear, increment, terminal-count output); all other logic SHALL be in the top module.
REQ-035 The module SHALL be synthesizable RTL and SHALL NOT be a black box.

Verification
REQ-036 Start+Enable, then 15 more Enable strobes carrying 0xA5C3 MSB-first (LEFT) -> Q=0xA5C3, Valid=1 one cycle after the 16th bit, Busy=0.
REQ-037 The same stream with lpm_direction="RIGHT" sent LSB-first -> Q=0xA5C3; Enable gaps of 0-3 cycles between bits -> identical result.
REQ-038 Word 0x1234 left unacked, then word 0xFFFF sent -> Q stays 0x1234, Overrun=1; ClrErr -> Overrun=0.
REQ-039 Ack in the same cycle as completion of 0x00FF -> Q=0x00FF, Valid=1, Overrun=0.
REQ-040 Start after 7 bits, then 16 bits of 0x8001 -> Q=0x8001, with no trace of the partial word.
REQ-041 Aclr_n pulsed low after 9 bits -> all outputs 0 immediately; the following Enable strobes without Start are ignored.
